// File: rtl/ddr_dly_pkg.sv
// ddr_dly_pkg
// Shared types for the DDR command/address delay-line step controller:
// the request mode encoding, the controller FSM states and the
// DIRECTION polarity constant.
package ddr_dly_pkg;

    typedef enum logic [1:0] {
        MODE_SET    = 2'b00,
        MODE_INC    = 2'b01,
        MODE_DEC    = 2'b10,
        MODE_RELOAD = 2'b11
    } req_mode_e;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_PREP,
        ST_MOVE,
        ST_SETTLE,
        ST_LOAD,
        ST_DONE
    } dly_state_e;

    localparam logic DIR_INC = 1'b1;

endpackage

// File: rtl/ddr_dly_tap_regs.sv
// ddr_dly_tap_regs
// Per-lane current-tap register file.
//   clk, rst          : clock, synchronous active-high reset (taps -> INIT_TAP)
//   wr_en/wr_lane/wr_tap : single write port
//   act_lane/act_tap  : combinational read of the lane being operated on
//   rd_lane/rd_tap    : registered readback port, 0 for lanes >= NUM_LANES
module ddr_dly_tap_regs #(
    parameter int NUM_LANES = 16,
    parameter int TAP_W     = 8,
    parameter int LANE_W    = 4,
    parameter int INIT_TAP  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [LANE_W-1:0] wr_lane,
    input  logic [TAP_W-1:0]  wr_tap,
    input  logic [LANE_W-1:0] act_lane,
    output logic [TAP_W-1:0]  act_tap,
    input  logic [LANE_W-1:0] rd_lane,
    output logic [TAP_W-1:0]  rd_tap
);

    localparam logic [TAP_W-1:0] INIT_T = TAP_W'(INIT_TAP);

    logic [TAP_W-1:0] taps [NUM_LANES];
    logic             wr_ok;
    logic             act_ok;
    logic             rd_ok;

    always_comb begin
        wr_ok  = 32'(wr_lane) < NUM_LANES;
        act_ok = 32'(act_lane) < NUM_LANES;
        rd_ok  = 32'(rd_lane) < NUM_LANES;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            taps <= '{default: INIT_T};
        end else if (wr_en && wr_ok) begin
            taps[wr_lane] <= wr_tap;
        end
    end

    always_comb begin
        act_tap = act_ok ? taps[act_lane] : '0;
    end

    // Write data is forwarded so the readback shows a new tap one cycle
    // after the cycle in which it is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_tap <= '0;
        end else if (!rd_ok) begin
            rd_tap <= '0;
        end else if (wr_en && wr_ok && (wr_lane == rd_lane)) begin
            rd_tap <= wr_tap;
        end else begin
            rd_tap <= taps[rd_lane];
        end
    end

endmodule

// File: rtl/ddr_ca_dly_ctrl.sv
// ddr_ca_dly_ctrl
// Multi-lane delay-line step controller for the DDR CA IOD lanes.
// Takes SET/INC/DEC/RELOAD requests over REQ_VALID/REQ_READY, steps the
// selected lane's delay line one MOVE pulse at a time with SETTLE_CYC idle
// cycles after each pulse, tracks every lane's tap and latches IOD
// out-of-range events.
//   FAB_CLK, SYNC_RST        : clock, synchronous active-high reset
//   REQ_*                    : request channel (lane, mode, value)
//   DONE, DONE_ERR           : completion pulse and error qualifier
//   RD_LANE, RD_TAP          : registered tap readback
//   DELAY_LINE_*             : per-lane IOD delay-line controls / status
//   OOR_STICKY, OOR_CLR      : latched out-of-range flags and their clear
module ddr_ca_dly_ctrl
    import ddr_dly_pkg::*;
#(
    parameter int NUM_LANES  = 16,
    parameter int TAP_W      = 8,
    parameter int MAX_TAP    = 255,
    parameter int INIT_TAP   = 1,
    parameter int SETTLE_CYC = 4,
    localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                 FAB_CLK,
    input  logic                 SYNC_RST,
    input  logic                 REQ_VALID,
    output logic                 REQ_READY,
    input  logic [LANE_W-1:0]    REQ_LANE,
    input  logic [1:0]           REQ_MODE,
    input  logic [TAP_W-1:0]     REQ_VAL,
    output logic                 DONE,
    output logic                 DONE_ERR,
    input  logic [LANE_W-1:0]    RD_LANE,
    output logic [TAP_W-1:0]     RD_TAP,
    output logic [NUM_LANES-1:0] DELAY_LINE_MOVE,
    output logic [NUM_LANES-1:0] DELAY_LINE_DIRECTION,
    output logic [NUM_LANES-1:0] DELAY_LINE_LOAD,
    input  logic [NUM_LANES-1:0] DELAY_LINE_OUT_OF_RANGE,
    output logic [NUM_LANES-1:0] OOR_STICKY,
    input  logic                 OOR_CLR
);

    localparam int                CNT_W    = $clog2(SETTLE_CYC + 1);
    localparam logic [TAP_W-1:0]  MAX_T    = TAP_W'(MAX_TAP);
    localparam logic [TAP_W-1:0]  INIT_T   = TAP_W'(INIT_TAP);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYC - 1);

    dly_state_e          state;
    req_mode_e           req_mode;
    req_mode_e           mode_q;
    logic [LANE_W-1:0]   lane_q;
    logic                dir_q;
    logic                err_q;
    logic [TAP_W-1:0]    steps_left;
    logic [CNT_W-1:0]    cnt;

    logic [NUM_LANES-1:0] move_r, dir_r, load_r, sticky_r;
    logic                 ready_r, done_r, done_err_r;

    logic [LANE_W-1:0]   act_lane;
    logic [TAP_W-1:0]    act_tap;
    logic                tap_we;
    logic [TAP_W-1:0]    tap_wdata;
    logic                last_settle;
    logic                oor_act;
    logic                req_lane_ok;
    logic [TAP_W-1:0]    acc_tgt, acc_n;
    logic                acc_dir, acc_err;

    ddr_dly_tap_regs #(
        .NUM_LANES (NUM_LANES),
        .TAP_W     (TAP_W),
        .LANE_W    (LANE_W),
        .INIT_TAP  (INIT_TAP)
    ) u_tap_regs (
        .clk      (FAB_CLK),
        .rst      (SYNC_RST),
        .wr_en    (tap_we),
        .wr_lane  (lane_q),
        .wr_tap   (tap_wdata),
        .act_lane (act_lane),
        .act_tap  (act_tap),
        .rd_lane  (RD_LANE),
        .rd_tap   (RD_TAP)
    );

    // In IDLE the active read port looks at the requested lane so the step
    // count can be computed in the accept cycle.
    always_comb begin
        req_mode    = req_mode_e'(REQ_MODE);
        act_lane    = (state == ST_IDLE) ? REQ_LANE : lane_q;
        req_lane_ok = 32'(REQ_LANE) < NUM_LANES;
        last_settle = (state == ST_SETTLE) && (cnt == CNT_LAST);
        oor_act     = DELAY_LINE_OUT_OF_RANGE[lane_q];
        tap_we      = last_settle && ((mode_q == MODE_RELOAD) || !oor_act);
        if (mode_q == MODE_RELOAD)
            tap_wdata = INIT_T;
        else if (dir_q == DIR_INC)
            tap_wdata = act_tap + TAP_W'(1);
        else
            tap_wdata = act_tap - TAP_W'(1);
    end

    // Step count, direction and saturation error for the incoming request.
    always_comb begin
        acc_tgt = act_tap;
        acc_n   = '0;
        acc_dir = DIR_INC;
        acc_err = 1'b0;
        case (req_mode)
            MODE_SET: begin
                if (REQ_VAL > MAX_T) begin
                    acc_tgt = MAX_T;
                    acc_err = 1'b1;
                end else begin
                    acc_tgt = REQ_VAL;
                end
                if (acc_tgt >= act_tap) begin
                    acc_dir = DIR_INC;
                    acc_n   = acc_tgt - act_tap;
                end else begin
                    acc_dir = ~DIR_INC;
                    acc_n   = act_tap - acc_tgt;
                end
            end
            MODE_INC: begin
                acc_dir = DIR_INC;
                if (REQ_VAL > (MAX_T - act_tap)) begin
                    acc_n   = MAX_T - act_tap;
                    acc_err = 1'b1;
                end else begin
                    acc_n = REQ_VAL;
                end
            end
            MODE_DEC: begin
                acc_dir = ~DIR_INC;
                if (REQ_VAL > act_tap) begin
                    acc_n   = act_tap;
                    acc_err = 1'b1;
                end else begin
                    acc_n = REQ_VAL;
                end
            end
            default: begin
                acc_n = '0;
            end
        endcase
    end

    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            state      <= ST_INIT;
            mode_q     <= MODE_SET;
            lane_q     <= '0;
            dir_q      <= DIR_INC;
            err_q      <= 1'b0;
            steps_left <= '0;
            cnt        <= '0;
            move_r     <= '0;
            dir_r      <= '0;
            load_r     <= '0;
            sticky_r   <= '0;
            ready_r    <= 1'b0;
            done_r     <= 1'b0;
            done_err_r <= 1'b0;
        end else begin
            move_r     <= '0;
            load_r     <= '0;
            done_r     <= 1'b0;
            done_err_r <= 1'b0;
            // A set issued later in this block overrides the clear.
            if (OOR_CLR)
                sticky_r <= '0;

            case (state)
                ST_INIT: begin
                    // First cycle raises LOAD on all lanes, second enters IDLE.
                    if (load_r == '0) begin
                        load_r <= '1;
                    end else begin
                        ready_r <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (REQ_VALID) begin
                        ready_r    <= 1'b0;
                        lane_q     <= REQ_LANE;
                        mode_q     <= req_mode;
                        dir_q      <= acc_dir;
                        err_q      <= acc_err;
                        steps_left <= acc_n;
                        if (!req_lane_ok) begin
                            done_r     <= 1'b1;
                            done_err_r <= 1'b1;
                            state      <= ST_DONE;
                        end else if (req_mode == MODE_RELOAD) begin
                            load_r[REQ_LANE] <= 1'b1;
                            state            <= ST_LOAD;
                        end else if (acc_n == '0) begin
                            done_r     <= 1'b1;
                            done_err_r <= acc_err;
                            state      <= ST_DONE;
                        end else begin
                            dir_r[REQ_LANE] <= acc_dir;
                            state           <= ST_PREP;
                        end
                    end
                end
                ST_PREP: begin
                    move_r[lane_q] <= 1'b1;
                    state          <= ST_MOVE;
                end
                ST_MOVE, ST_LOAD: begin
                    cnt   <= '0;
                    state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt != CNT_LAST) begin
                        cnt <= cnt + CNT_W'(1);
                    end else if (mode_q == MODE_RELOAD) begin
                        done_r <= 1'b1;
                        state  <= ST_DONE;
                    end else if (oor_act) begin
                        sticky_r[lane_q] <= 1'b1;
                        done_r           <= 1'b1;
                        done_err_r       <= 1'b1;
                        state            <= ST_DONE;
                    end else if (steps_left == TAP_W'(1)) begin
                        done_r     <= 1'b1;
                        done_err_r <= err_q;
                        state      <= ST_DONE;
                    end else begin
                        steps_left     <= steps_left - TAP_W'(1);
                        move_r[lane_q] <= 1'b1;
                        state          <= ST_MOVE;
                    end
                end
                ST_DONE: begin
                    ready_r <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

    always_comb begin
        REQ_READY            = ready_r;
        DONE                 = done_r;
        DONE_ERR             = done_err_r;
        DELAY_LINE_MOVE      = move_r;
        DELAY_LINE_DIRECTION = dir_r;
        DELAY_LINE_LOAD      = load_r;
        OOR_STICKY           = sticky_r;
    end

endmodule

// File: tb/tb_ddr_ca_dly_ctrl.sv
// tb_ddr_ca_dly_ctrl
// Directed bench for ddr_ca_dly_ctrl with 12 lanes (non power of two, so
// out-of-range lane numbers are reachable) and SETTLE_CYC = 4.
module tb_ddr_ca_dly_ctrl;

    localparam int NL = 12;

    logic          FAB_CLK;
    logic          SYNC_RST;
    logic          REQ_VALID;
    logic          REQ_READY;
    logic [3:0]    REQ_LANE;
    logic [1:0]    REQ_MODE;
    logic [7:0]    REQ_VAL;
    logic          DONE;
    logic          DONE_ERR;
    logic [3:0]    RD_LANE;
    logic [7:0]    RD_TAP;
    logic [NL-1:0] DELAY_LINE_MOVE;
    logic [NL-1:0] DELAY_LINE_DIRECTION;
    logic [NL-1:0] DELAY_LINE_LOAD;
    logic [NL-1:0] oor_in;
    logic [NL-1:0] OOR_STICKY;
    logic          OOR_CLR;

    int n_checks = 0;
    int n_errors = 0;

    // Per-request observations.
    int mv_q[$];
    int ld_cyc, ld_val, dn_cyc, dn_err, rdy_at_done, bad_pulse, dir_flip, dir_c1;
    int oor_lane  = -1;
    int oor_after = 0;

    ddr_ca_dly_ctrl #(
        .NUM_LANES  (NL),
        .TAP_W      (8),
        .MAX_TAP    (255),
        .INIT_TAP   (1),
        .SETTLE_CYC (4)
    ) dut (
        .FAB_CLK                 (FAB_CLK),
        .SYNC_RST                (SYNC_RST),
        .REQ_VALID               (REQ_VALID),
        .REQ_READY               (REQ_READY),
        .REQ_LANE                (REQ_LANE),
        .REQ_MODE                (REQ_MODE),
        .REQ_VAL                 (REQ_VAL),
        .DONE                    (DONE),
        .DONE_ERR                (DONE_ERR),
        .RD_LANE                 (RD_LANE),
        .RD_TAP                  (RD_TAP),
        .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
        .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
        .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
        .DELAY_LINE_OUT_OF_RANGE (oor_in),
        .OOR_STICKY              (OOR_STICKY),
        .OOR_CLR                 (OOR_CLR)
    );

    initial FAB_CLK = 1'b0;
    always #5 FAB_CLK = ~FAB_CLK;

    task automatic chk(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge (sampling/driving phase).
    task automatic tick();
        @(posedge FAB_CLK);
        #1;
    endtask

    task automatic rd_chk(input string tag, input int lane, input int exp);
        RD_LANE = 4'(lane);
        tick();
        chk(tag, RD_TAP, exp);
    endtask

    task automatic reset_seq(input string tag);
        int w;
        int dn;
        SYNC_RST = 1'b1;
        tick();
        tick();
        chk({tag, "_rst_ready"}, REQ_READY, 0);
        chk({tag, "_rst_load"}, DELAY_LINE_LOAD, 0);
        chk({tag, "_rst_move_dir_done"},
            {DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DONE}, 0);
        SYNC_RST = 1'b0;
        w  = 0;
        dn = 0;
        while (DELAY_LINE_LOAD == '0 && w < 5) begin
            tick();
            if (DONE === 1'b1) dn++;
            w++;
        end
        chk({tag, "_init_load"}, DELAY_LINE_LOAD, 12'hFFF);
        chk({tag, "_init_ready_low"}, REQ_READY, 0);
        tick();
        chk({tag, "_init_load_off"}, DELAY_LINE_LOAD, 0);
        chk({tag, "_idle_ready"}, REQ_READY, 1);
        chk({tag, "_no_done"}, dn, 0);
    endtask

    task automatic do_req(input int lane, input int mode, input int val, input int max_cyc);
        int w;
        w = 0;
        while (REQ_READY !== 1'b1 && w < 100) begin
            tick();
            w++;
        end
        chk("req_ready", REQ_READY, 1);
        REQ_LANE  = 4'(lane);
        REQ_MODE  = 2'(mode);
        REQ_VAL   = 8'(val);
        REQ_VALID = 1'b1;
        tick();
        REQ_VALID = 1'b0;
        mv_q.delete();
        ld_cyc = -1; ld_val = 0; dn_cyc = -1; dn_err = 0;
        rdy_at_done = 0; bad_pulse = 0; dir_flip = 0;
        dir_c1 = (lane < NL) ? int'(DELAY_LINE_DIRECTION[lane]) : 0;
        for (int c = 1; c <= max_cyc; c++) begin
            if (DELAY_LINE_MOVE != '0) begin
                mv_q.push_back(c);
                if (DELAY_LINE_MOVE != (12'(1) << lane)) bad_pulse++;
            end
            if (DELAY_LINE_LOAD != '0) begin
                if (ld_cyc < 0) begin
                    ld_cyc = c;
                    ld_val = int'(DELAY_LINE_LOAD);
                end else begin
                    bad_pulse++;
                end
            end
            if (lane < NL && int'(DELAY_LINE_DIRECTION[lane]) != dir_c1) dir_flip++;
            if (oor_lane >= 0 && mv_q.size() == oor_after) oor_in[oor_lane] = 1'b1;
            if (DONE === 1'b1) begin
                dn_cyc      = c;
                dn_err      = int'(DONE_ERR);
                rdy_at_done = int'(REQ_READY);
                break;
            end
            tick();
        end
        if (dn_cyc < 0) begin
            chk("done_timeout", 0, 1);
        end else begin
            chk("ready_low_at_done", rdy_at_done, 0);
            tick();
            chk("ready_after_done", REQ_READY, 1);
            chk("done_one_cycle", DONE, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        SYNC_RST = 1'b1; REQ_VALID = 1'b0; REQ_LANE = '0; REQ_MODE = '0;
        REQ_VAL = '0; RD_LANE = '0; oor_in = '0; OOR_CLR = 1'b0;

        reset_seq("por");
        rd_chk("por_tap0", 0, 1);
        rd_chk("por_tap11", 11, 1);
        rd_chk("rd_lane_oob", 13, 0);

        // SET lane 3 from 1 to 4: moves at 2, 7, 12; done at 17.
        do_req(3, 0, 4, 40);
        chk("set3_dir", dir_c1, 1);
        chk("set3_moves", mv_q.size(), 3);
        if (mv_q.size() == 3) begin
            chk("set3_mv0", mv_q[0], 2);
            chk("set3_mv1", mv_q[1], 7);
            chk("set3_mv2", mv_q[2], 12);
        end
        chk("set3_done_cyc", dn_cyc, 17);
        chk("set3_err", dn_err, 0);
        chk("set3_pulse_shape", bad_pulse + dir_flip, 0);
        rd_chk("set3_tap", 3, 4);

        // DEC lane 3 by 10 from 4: saturates at 0 after 4 steps.
        do_req(3, 2, 10, 40);
        chk("dec3_dir", dir_c1, 0);
        chk("dec3_moves", mv_q.size(), 4);
        chk("dec3_done_cyc", dn_cyc, 22);
        chk("dec3_err", dn_err, 1);
        chk("dec3_pulse_shape", bad_pulse + dir_flip, 0);
        rd_chk("dec3_tap", 3, 0);

        // SET lane 3 to its current tap: no movement, done at cycle 1.
        do_req(3, 0, 0, 10);
        chk("nop_moves", mv_q.size(), 0);
        chk("nop_done_cyc", dn_cyc, 1);
        chk("nop_err", dn_err, 0);

        // SET lane 5 to 20, IOD reports out-of-range from the 3rd step.
        oor_lane  = 5;
        oor_after = 3;
        do_req(5, 0, 20, 120);
        oor_lane = -1;
        oor_in   = '0;
        chk("oor5_moves", mv_q.size(), 3);
        chk("oor5_done_cyc", dn_cyc, 17);
        chk("oor5_err", dn_err, 1);
        chk("oor5_sticky", OOR_STICKY, 12'h020);
        rd_chk("oor5_tap", 5, 3);
        OOR_CLR = 1'b1;
        tick();
        OOR_CLR = 1'b0;
        chk("oor_clr", OOR_STICKY, 0);

        // Bring lane 0 to 9, then RELOAD: LOAD at 1, done at 6, tap back to 1.
        do_req(0, 0, 9, 60);
        chk("set0_moves", mv_q.size(), 8);
        rd_chk("set0_tap", 0, 9);
        do_req(0, 3, 0, 20);
        chk("rl0_load_cyc", ld_cyc, 1);
        chk("rl0_load_val", ld_val, 1);
        chk("rl0_moves", mv_q.size(), 0);
        chk("rl0_done_cyc", dn_cyc, 6);
        chk("rl0_err", dn_err, 0);
        rd_chk("rl0_tap", 0, 1);

        // INC lane 2 by 2 while an idle lane reports out-of-range.
        oor_in[1] = 1'b1;
        do_req(2, 1, 2, 30);
        chk("inc2_moves", mv_q.size(), 2);
        chk("inc2_done_cyc", dn_cyc, 12);
        chk("inc2_err", dn_err, 0);
        chk("inc2_sticky_clean", OOR_STICKY, 0);
        oor_in[1] = 1'b0;
        rd_chk("inc2_tap", 2, 3);

        // Lane number beyond NUM_LANES: error completion, no pulses.
        do_req(13, 1, 1, 10);
        chk("oob_done_cyc", dn_cyc, 1);
        chk("oob_err", dn_err, 1);
        chk("oob_pulses", mv_q.size() + (ld_cyc >= 0 ? 1 : 0), 0);

        // Saturate at MAX_TAP: lane 7 to 254, then INC by 3 moves only once.
        do_req(7, 0, 254, 1400);
        chk("set7_moves", mv_q.size(), 253);
        chk("set7_err", dn_err, 0);
        do_req(7, 1, 3, 20);
        chk("inc7_moves", mv_q.size(), 1);
        chk("inc7_done_cyc", dn_cyc, 7);
        chk("inc7_err", dn_err, 1);
        rd_chk("inc7_tap", 7, 255);

        // Reset in the middle of a 10-step INC on lane 2.
        begin
            int dn;
            dn = 0;
            REQ_LANE = 4'd2; REQ_MODE = 2'd1; REQ_VAL = 8'd10; REQ_VALID = 1'b1;
            tick();
            REQ_VALID = 1'b0;
            for (int c = 1; c <= 20; c++) begin
                if (DONE === 1'b1) dn++;
                tick();
            end
            chk("midrst_no_done_before", dn, 0);
        end
        reset_seq("midrst");
        rd_chk("midrst_tap2", 2, 1);
        rd_chk("midrst_tap3", 3, 1);
        rd_chk("midrst_tap7", 7, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
